guard_reset_ctrl: RTL and testbench

Reset sequencer downstream of the AXI write and read guards. It consumes their `reset_req_o`/`irq_o` outputs and runs a fixed recovery sequence: isolate the guarded slave, drain or time out, hold the slave in reset, then release it. It also freezes the guards during recovery and reports the cause and event count to software. It sits between the guards and the slave-side isolation/reset fabric.

---
 rtl/guard_reset_pkg.sv | 30 +++
 rtl/guard_reset_timer.sv | 32 +++
 rtl/guard_reset_ctrl.sv | 145 ++++++++++++++
 tb/tb_guard_reset_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/guard_reset_pkg.sv
// Shared types for the guard reset sequencer: FSM state encoding, the latched cause
// record, and the timer-width helper.
package guard_reset_pkg;

  typedef enum logic [2:0] {
    GRS_IDLE,
    GRS_DRAIN,
    GRS_HOLD,
    GRS_RECOVER,
    GRS_DONE
  } grs_state_e;

  typedef struct packed {
    logic missed;
    logic rd;
    logic wr;
  } grs_cause_t;

  // The timer must hold the largest (count - 1) load value, and it is never narrower than 1 bit.
  function automatic int grs_timer_width(int a, int b, int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/guard_reset_timer.sv
// Loadable down-counter. It stops at zero and is shared by the DRAIN, HOLD and RECOVER
// phases of the guard reset sequencer.
module guard_reset_timer #(
  parameter int Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state is updated only with non-blocking assignments and reset synchronously, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/guard_reset_ctrl.sv
// Reset sequencer behind the AXI read/write guards: isolate, drain, hold, recover, done.
// Macro GUARD_RESET_AUTOCLR_EN makes DONE return to IDLE by itself after one cycle.
module guard_reset_ctrl
  import guard_reset_pkg::*;
#(
  parameter int DrainCycles   = 64,
  parameter int HoldCycles    = 16,
  parameter int RecoverCycles = 8,
  parameter int EvtCntWidth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_reset_req_i,
  input  logic                   rd_reset_req_i,
  input  logic                   reset_clear_i,
  input  logic                   isolated_i,
  output logic                   isolate_o,
  output logic                   slv_rst_no,
  output logic                   guard_ena_o,
  output logic                   irq_o,
  output logic [2:0]             cause_o,
  output logic                   drain_timeout_o,
  output logic                   busy_o,
  output logic [EvtCntWidth-1:0] evt_cnt_o
);

  if (DrainCycles < 1 || HoldCycles < 1 || RecoverCycles < 1) begin : g_bad_cycles
    $error("guard_reset_ctrl: DrainCycles, HoldCycles and RecoverCycles must all be >= 1");
  end

  localparam int TimerW = grs_timer_width(DrainCycles, HoldCycles, RecoverCycles);
  localparam logic [TimerW-1:0] DrainLoad   = TimerW'(DrainCycles - 1);
  localparam logic [TimerW-1:0] HoldLoad    = TimerW'(HoldCycles - 1);
  localparam logic [TimerW-1:0] RecoverLoad = TimerW'(RecoverCycles - 1);

  grs_state_e             state_d, state_q;
  grs_cause_t             cause_d, cause_q;
  logic                   irq_d, irq_q;
  logic                   dto_d, dto_q;
  logic [EvtCntWidth-1:0] evt_d, evt_q;
  logic                   tmr_load;
  logic [TimerW-1:0]      tmr_val;
  logic                   tmr_zero;
  logic                   req;

  assign req = wr_reset_req_i | rd_reset_req_i;

  guard_reset_timer #(.Width(TimerW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  // NOTE: every variable is given a default first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    irq_d    = irq_q;
    dto_d    = dto_q;
    evt_d    = evt_q;
    tmr_load = 1'b0;
    tmr_val  = DrainLoad;

    // A request that arrives mid-sequence is only recorded. It never restarts the sequence.
    if (req && state_q != GRS_IDLE) cause_d.missed = 1'b1;

    case (state_q)
      GRS_IDLE: begin
        if (reset_clear_i) begin
          irq_d   = 1'b0;
          cause_d = '0;
        end
        if (req) begin
          cause_d  = '{missed: 1'b0, rd: rd_reset_req_i, wr: wr_reset_req_i};
          dto_d    = 1'b0;
          irq_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = DrainLoad;
          state_d  = GRS_DRAIN;
        end
      end
      GRS_DRAIN: begin
        if (isolated_i || tmr_zero) begin
          dto_d    = !isolated_i;
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
          state_d  = GRS_HOLD;
        end
      end
      GRS_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = RecoverLoad;
          state_d  = GRS_RECOVER;
        end
      end
      GRS_RECOVER: begin
        if (tmr_zero) begin
          if (evt_q != '1) evt_d = evt_q + 1'b1;
          state_d = GRS_DONE;
        end
      end
      GRS_DONE: begin
`ifdef GUARD_RESET_AUTOCLR_EN
        state_d = GRS_IDLE;
`else
        if (reset_clear_i) state_d = GRS_IDLE;
`endif
        if (reset_clear_i) begin
          irq_d   = 1'b0;
          cause_d = '0;
        end
      end
      default: state_d = GRS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= GRS_IDLE;
      cause_q <= '0;
      irq_q   <= 1'b0;
      dto_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      irq_q   <= irq_d;
      dto_q   <= dto_d;
      evt_q   <= evt_d;
    end
  end

  assign isolate_o       = (state_q == GRS_DRAIN) || (state_q == GRS_HOLD) || (state_q == GRS_RECOVER);
  assign slv_rst_no      = (state_q != GRS_HOLD);
  assign guard_ena_o     = (state_q == GRS_IDLE) || (state_q == GRS_DONE);
  assign busy_o          = (state_q != GRS_IDLE);
  assign irq_o           = irq_q;
  assign cause_o         = cause_q;
  assign drain_timeout_o = dto_q;
  assign evt_cnt_o       = evt_q;

endmodule

// File: tb/tb_guard_reset_ctrl.sv
// Directed bench for guard_reset_ctrl. It runs a cycle-table walk through three sequences,
// then hand-written checks for latency, counter saturation, a request in DONE, and reset during HOLD.
module tb_guard_reset_ctrl;

`ifdef GUARD_RESET_AUTOCLR_EN
  localparam logic DoneBusy = 1'b0;
`else
  localparam logic DoneBusy = 1'b1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_reset_req_i = 1'b0;
  logic       rd_reset_req_i = 1'b0;
  logic       reset_clear_i = 1'b0;
  logic       isolated_i = 1'b0;
  logic       isolate_o, slv_rst_no, guard_ena_o, irq_o, drain_timeout_o, busy_o;
  logic [2:0] cause_o;
  logic [1:0] evt_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  guard_reset_ctrl #(
    .DrainCycles  (64),
    .HoldCycles   (16),
    .RecoverCycles(8),
    .EvtCntWidth  (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_reset_req_i (wr_reset_req_i),
    .rd_reset_req_i (rd_reset_req_i),
    .reset_clear_i  (reset_clear_i),
    .isolated_i     (isolated_i),
    .isolate_o      (isolate_o),
    .slv_rst_no     (slv_rst_no),
    .guard_ena_o    (guard_ena_o),
    .irq_o          (irq_o),
    .cause_o        (cause_o),
    .drain_timeout_o(drain_timeout_o),
    .busy_o         (busy_o),
    .evt_cnt_o      (evt_cnt_o)
  );

  typedef struct {
    int unsigned cyc;
    logic wr, rd, clr, iso, rst_n;
    logic e_iso, e_srst, e_ena, e_irq;
    logic [2:0] e_cause;
    logic e_dto, e_busy;
    logic [1:0] e_evt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int unsigned cyc, logic wr, logic rd, logic clr, logic iso, logic rst_n,
                              logic e_iso, logic e_srst, logic e_ena, logic e_irq, logic [2:0] e_cause,
                              logic e_dto, logic e_busy, logic [1:0] e_evt);
    vec_t v;
    v.cyc = cyc; v.wr = wr; v.rd = rd; v.clr = clr; v.iso = iso; v.rst_n = rst_n;
    v.e_iso = e_iso; v.e_srst = e_srst; v.e_ena = e_ena; v.e_irq = e_irq;
    v.e_cause = e_cause; v.e_dto = e_dto; v.e_busy = e_busy; v.e_evt = e_evt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".isolate"}, 32'(isolate_o), 32'(v.e_iso));
    check({tag, ".slv_rst_n"}, 32'(slv_rst_no), 32'(v.e_srst));
    check({tag, ".guard_ena"}, 32'(guard_ena_o), 32'(v.e_ena));
    check({tag, ".irq"}, 32'(irq_o), 32'(v.e_irq));
    check({tag, ".cause"}, 32'(cause_o), 32'(v.e_cause));
    check({tag, ".drain_to"}, 32'(drain_timeout_o), 32'(v.e_dto));
    check({tag, ".busy"}, 32'(busy_o), 32'(v.e_busy));
    check({tag, ".evt_cnt"}, 32'(evt_cnt_o), 32'(v.e_evt));
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // A request pulse with isolated_i already high reaches guard_ena_o=1 after 1+1+16+8 = 26 edges.
  task automatic run_min_seq(input string tag);
    int n;
    isolated_i = 1'b1;
    wr_reset_req_i = 1'b1;
    tick(1);
    wr_reset_req_i = 1'b0;
    n = 1;
    while (!guard_ena_o && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd26);
    check({tag, ".evt_sat"}, 32'(evt_cnt_o), 32'd3);
    isolated_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Columns: cycles, wr rd clr iso rst_n | isolate slv_rst_n guard_ena irq cause dto busy evt
    // Sequence 1: wr pulse, isolated after 3 DRAIN cycles, clear in DONE.
    vecs.push_back(mk(2,  0,0,0,0,0, 0,1,1,0,3'b000,0,0,0));
    vecs.push_back(mk(1,  1,0,0,0,1, 1,1,0,1,3'b001,0,1,0));
    vecs.push_back(mk(2,  0,0,0,0,1, 1,1,0,1,3'b001,0,1,0));
    vecs.push_back(mk(1,  0,0,0,1,1, 1,0,0,1,3'b001,0,1,0));
    vecs.push_back(mk(15, 0,0,0,0,1, 1,0,0,1,3'b001,0,1,0));
    vecs.push_back(mk(1,  0,0,0,0,1, 1,1,0,1,3'b001,0,1,0));
    vecs.push_back(mk(7,  0,0,0,0,1, 1,1,0,1,3'b001,0,1,0));
    vecs.push_back(mk(1,  0,0,0,0,1, 0,1,1,1,3'b001,0,1,1));
    vecs.push_back(mk(1,  0,0,0,0,1, 0,1,1,1,3'b001,0,DoneBusy,1));
    vecs.push_back(mk(1,  0,0,1,0,1, 0,1,1,0,3'b000,0,0,1));
    // Sequence 2: rd request, drain timeout after 64 DRAIN cycles.
    vecs.push_back(mk(1,  0,1,0,0,1, 1,1,0,1,3'b010,0,1,1));
    vecs.push_back(mk(63, 0,0,0,0,1, 1,1,0,1,3'b010,0,1,1));
    vecs.push_back(mk(1,  0,0,0,0,1, 1,0,0,1,3'b010,1,1,1));
    vecs.push_back(mk(16, 0,0,0,0,1, 1,1,0,1,3'b010,1,1,1));
    vecs.push_back(mk(8,  0,0,0,0,1, 0,1,1,1,3'b010,1,1,2));
    vecs.push_back(mk(1,  0,0,1,0,1, 0,1,1,0,3'b000,1,0,2));
    // Sequence 3: wr+rd together, rd again in HOLD (missed), clear in HOLD ignored.
    vecs.push_back(mk(1,  1,1,0,0,1, 1,1,0,1,3'b011,0,1,2));
    vecs.push_back(mk(1,  0,0,0,1,1, 1,0,0,1,3'b011,0,1,2));
    vecs.push_back(mk(1,  0,1,0,0,1, 1,0,0,1,3'b111,0,1,2));
    vecs.push_back(mk(1,  0,0,1,0,1, 1,0,0,1,3'b111,0,1,2));
    vecs.push_back(mk(13, 0,0,0,0,1, 1,0,0,1,3'b111,0,1,2));
    vecs.push_back(mk(1,  0,0,0,0,1, 1,1,0,1,3'b111,0,1,2));
    vecs.push_back(mk(8,  0,0,0,0,1, 0,1,1,1,3'b111,0,1,3));
    vecs.push_back(mk(3,  0,0,0,0,1, 0,1,1,1,3'b111,0,DoneBusy,3));
    vecs.push_back(mk(1,  0,0,1,0,1, 0,1,1,0,3'b000,0,0,3));

    for (int i = 0; i < vecs.size(); i++) begin
      wr_reset_req_i = vecs[i].wr;
      rd_reset_req_i = vecs[i].rd;
      reset_clear_i  = vecs[i].clr;
      isolated_i     = vecs[i].iso;
      rst_ni         = vecs[i].rst_n;
      tick(vecs[i].cyc);
      check_all($sformatf("row%0d", i), vecs[i]);
    end
    reset_clear_i = 1'b0;

    // Two more sequences: minimum latency, and the 2-bit counter stays saturated at 3.
    for (int s = 0; s < 2; s++) begin
      run_min_seq($sformatf("sat%0d", s));
`ifndef GUARD_RESET_AUTOCLR_EN
      rd_reset_req_i = 1'b1;
      tick(1);
      rd_reset_req_i = 1'b0;
      check($sformatf("sat%0d.done_missed", s), 32'(cause_o), 32'b101);
      check($sformatf("sat%0d.done_stays", s), 32'(busy_o), 32'd1);
`endif
      reset_clear_i = 1'b1;
      tick(1);
      reset_clear_i = 1'b0;
      check($sformatf("sat%0d.clr_irq", s), 32'(irq_o), 32'd0);
      check($sformatf("sat%0d.clr_idle", s), 32'(busy_o), 32'd0);
    end

    // Reset asserted in the middle of HOLD.
    isolated_i = 1'b1;
    wr_reset_req_i = 1'b1;
    tick(1);
    wr_reset_req_i = 1'b0;
    tick(4);
    check("rsthold.in_hold", 32'(slv_rst_no), 32'd0);
    rst_ni = 1'b0;
    tick(1);
    check("rsthold.slv_rst_n", 32'(slv_rst_no), 32'd1);
    check("rsthold.isolate", 32'(isolate_o), 32'd0);
    check("rsthold.guard_ena", 32'(guard_ena_o), 32'd1);
    check("rsthold.evt_cnt", 32'(evt_cnt_o), 32'd0);
    check("rsthold.irq", 32'(irq_o), 32'd0);
    check("rsthold.cause", 32'(cause_o), 32'd0);
    check("rsthold.busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    isolated_i = 1'b0;
    tick(2);
    check("rsthold.stays_idle", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
